s3_unpack: RTL and testbench

Streaming unpacker for ternary polynomials in S3. Each input byte carries 5 trits as b = t0 + 3·t1 + 9·t2 + 27·t3 + 81·t4. The block splits each byte back into its base-3 digits and emits them one per cycle, least-significant first, until N_TRITS coefficients have been produced. It is the decode side of the trit5-to-byte packing used in encapsulation, and it feeds the decapsulation datapath (ciphertext and private-key unpacking).

---
 rtl/s3_unpack.sv | 162 ++++++++++++++++
 tb/tb_s3_unpack.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3_unpack.sv
// s3_unpack: streaming unpacker for ternary polynomials.
// Each input byte holds five trits (b = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4).
// The trits come out one per cycle, least-significant first, until N_TRITS
// coefficients have been produced.
module s3_unpack #(
  parameter int N_TRITS = 700,
  parameter int IDX_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_trit,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Index of the final coefficient of the polynomial.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TRITS - 1);

  // Bytes at or above 3^5 cannot come from five trits.
  localparam logic [7:0] BYTE_LIMIT = 8'd243;

  state_t           state_reg, state_next;
  logic [7:0]       r_reg, r_next;
  logic [2:0]       dig_reg, dig_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;

  // Divide-by-3 of the working remainder, one restoring step per bit,
  // MSB first. rem_chain[gi] is the running remainder entering the step
  // for bit (7 - gi); the remainder never exceeds 2, so each partial value
  // fits in 3 bits and at most one subtraction of 3 is needed per step.
  logic [1:0] rem_chain [0:8];
  logic [7:0] r_quot;
  logic [1:0] r_mod3;

  assign rem_chain[0] = 2'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div3
      logic [2:0] partial;
      assign partial          = {rem_chain[gi], r_reg[7 - gi]};
      assign r_quot[7 - gi]   = (partial >= 3'd3);
      assign rem_chain[gi + 1] = (partial >= 3'd3) ? 2'(partial - 3'd3)
                                                   : partial[1:0];
    end
  endgenerate

  assign r_mod3 = rem_chain[8];

  logic at_last;
  logic take_trit;
  logic take_byte;

  assign at_last   = (cnt_reg == LAST_IDX);
  assign take_trit = (state_reg == S_EMIT) && out_ready;
  assign take_byte = (state_reg == S_LOAD) && in_valid;

  // Port outputs decode from the state only; data outputs are zero
  // whenever no trit is being presented.
  assign in_ready  = (state_reg == S_LOAD);
  assign out_valid = (state_reg == S_EMIT);
  assign out_trit  = out_valid ? r_mod3 : 2'd0;
  assign out_index = out_valid ? cnt_reg : '0;
  assign out_last  = out_valid && at_last;
  assign done      = (state_reg == S_DONE);
  assign err       = err_reg;

  // Next-state and datapath update; start overrides any handshake.
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    dig_next   = dig_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;

    case (state_reg)
      S_IDLE: begin
        state_next = S_IDLE;
      end

      S_LOAD: begin
        if (take_byte) begin
          r_next     = in_byte;
          dig_next   = 3'd0;
          state_next = S_EMIT;
          if (in_byte >= BYTE_LIMIT) begin
            err_next = 1'b1;
          end
        end
      end

      S_EMIT: begin
        if (take_trit) begin
          r_next   = r_quot;
          dig_next = dig_reg + 3'd1;
          cnt_next = cnt_reg + IDX_W'(1);
          if (at_last) begin
            state_next = S_DONE;
            // Padding trits above the last coefficient must be zero.
            if (r_quot != 8'd0) begin
              err_next = 1'b1;
            end
          end else if (dig_reg == 3'd4) begin
            state_next = S_LOAD;
            dig_next   = 3'd0;
          end else begin
            state_next = S_EMIT;
          end
        end
      end

      S_DONE: begin
        state_next = S_DONE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (start) begin
      state_next = S_LOAD;
      cnt_next   = '0;
      dig_next   = 3'd0;
      err_next   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      r_reg     <= 8'd0;
      dig_reg   <= 3'd0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      dig_reg   <= dig_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_s3_unpack.sv
// Testbench for s3_unpack: two instances (700 trits and 7 trits) checked
// every cycle against a queue/array model built from base-3 arithmetic,
// plus directed scenarios with literal expectations.
module tb_s3_unpack;

  localparam int NA = 700;
  localparam int NB = 7;
  localparam int IW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_s     [2];
  logic          in_valid_s  [2];
  logic [7:0]    in_byte_s   [2];
  logic          out_ready_s [2];
  logic          in_ready_o  [2];
  logic          out_valid_o [2];
  logic [1:0]    out_trit_o  [2];
  logic [IW-1:0] out_index_o [2];
  logic          out_last_o  [2];
  logic          done_o      [2];
  logic          err_o       [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      s3_unpack #(
        .N_TRITS((gi == 0) ? NA : NB),
        .IDX_W  (IW)
      ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s[gi]),
        .in_valid (in_valid_s[gi]),
        .in_byte  (in_byte_s[gi]),
        .in_ready (in_ready_o[gi]),
        .out_valid(out_valid_o[gi]),
        .out_trit (out_trit_o[gi]),
        .out_ready(out_ready_s[gi]),
        .out_index(out_index_o[gi]),
        .out_last (out_last_o[gi]),
        .done     (done_o[gi]),
        .err      (err_o[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  // Model state per unit.
  bit         active  [2];
  bit         done_e  [2];
  bit         err_e   [2];
  bit         pad_e   [2];
  int         nbytes  [2];
  int         ntaken  [2];
  logic [1:0] exp_trit [2][1024];
  logic [1:0] cap      [2][1024];
  int         cap_n    [2];
  int         cap_last [2];

  function automatic int ntr(input int u);
    return (u == 0) ? NA : NB;
  endfunction

  task automatic chk(input string name, input int u, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s u%0d: got %0d, want %0d", name, u, act, req);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    int  n;
    int  avail;
    int  k0;
    int  v;
    bit  e_ov;
    bit  e_ir;
    for (int u = 0; u < 2; u++) begin
      n     = ntr(u);
      avail = (((5 * nbytes[u]) < n) ? (5 * nbytes[u]) : n) - ntaken[u];
      e_ov  = active[u] && !done_e[u] && (avail > 0);
      e_ir  = active[u] && !done_e[u] && (avail == 0);

      if (mon_en) begin
        chk("out_valid", u, int'(out_valid_o[u]), int'(e_ov));
        chk("in_ready",  u, int'(in_ready_o[u]),  int'(e_ir));
        chk("done",      u, int'(done_o[u]),      int'(done_e[u]));
        chk("err",       u, int'(err_o[u]),       int'(err_e[u]));
        if (e_ov) begin
          chk("out_trit",  u, int'(out_trit_o[u]),  int'(exp_trit[u][ntaken[u]]));
          chk("out_index", u, int'(out_index_o[u]), ntaken[u]);
          chk("out_last",  u, int'(out_last_o[u]),  int'(ntaken[u] == n - 1));
        end
        if (!active[u]) begin
          chk("idle_index", u, int'(out_index_o[u]), 0);
          chk("idle_trit",  u, int'(out_trit_o[u]),  0);
        end
      end

      if (rst) begin
        active[u] = 1'b0; done_e[u] = 1'b0; err_e[u] = 1'b0;
        nbytes[u] = 0;    ntaken[u] = 0;
      end else if (start_s[u]) begin
        active[u] = 1'b1; done_e[u] = 1'b0; err_e[u] = 1'b0;
        nbytes[u] = 0;    ntaken[u] = 0;
        cap_n[u]  = 0;    cap_last[u] = -1;
      end else begin
        if (e_ir && in_valid_s[u]) begin
          k0 = 5 * nbytes[u];
          v  = int'(in_byte_s[u]);
          for (int d = 0; d < 5; d++) begin
            if (k0 + d < n) begin
              exp_trit[u][k0 + d] = 2'(v % 3);
              v = v / 3;
            end
          end
          pad_e[u] = (k0 + 5 >= n) && (v != 0);
          if (in_byte_s[u] >= 8'd243) err_e[u] = 1'b1;
          nbytes[u]++;
        end
        if (e_ov && out_ready_s[u]) begin
          cap[u][ntaken[u]] = out_trit_o[u];
          cap_n[u]++;
          if (out_last_o[u]) cap_last[u] = ntaken[u];
          if (ntaken[u] == n - 1) begin
            done_e[u] = 1'b1;
            if (pad_e[u]) err_e[u] = 1'b1;
          end
          ntaken[u]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int u);
    start_s[u] = 1'b1;
    tick();
    start_s[u] = 1'b0;
  endtask

  task automatic wait_ir(input int u);
    int k = 0;
    while (!in_ready_o[u] && k < 2000) begin
      tick();
      k++;
    end
    chk("wait_in_ready", u, int'(in_ready_o[u]), 1);
  endtask

  task automatic wait_done(input int u);
    int k = 0;
    while (!done_o[u] && k < 2000) begin
      tick();
      k++;
    end
    chk("wait_done", u, int'(done_o[u]), 1);
  endtask

  task automatic send_byte(input int u, input logic [7:0] b);
    in_valid_s[u] = 1'b1;
    in_byte_s[u]  = b;
    wait_ir(u);
    tick();
    in_valid_s[u] = 1'b0;
  endtask

  task automatic chk_cap5(input int u, input int base, input int v [5]);
    for (int i = 0; i < 5; i++)
      chk("cap_trit", u, int'(cap[u][base + i]), v[i]);
  endtask

  initial begin
    int cycles;

    // Reset with start and in_valid also asserted: reset must win.
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b1; in_valid_s[u] = 1'b1;
      in_byte_s[u] = 8'hF2; out_ready_s[u] = 1'b1;
    end
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_in_ready",  0, int'(in_ready_o[0]),  0);
    chk("rst_out_valid", 0, int'(out_valid_o[0]), 0);
    chk("rst_done",      0, int'(done_o[0]),      0);
    chk("rst_err",       0, int'(err_o[0]),       0);
    chk("rst_index",     0, int'(out_index_o[0]), 0);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; in_valid_s[u] = 1'b0;
    end
    tick();

    // Byte decode: 242 -> 2,2,2,2,2 ; 45 -> 0,0,2,1,0.
    pulse_start(0);
    send_byte(0, 8'hF2);
    send_byte(0, 8'h2D);
    wait_ir(0);
    chk_cap5(0, 0, '{2, 2, 2, 2, 2});
    chk_cap5(0, 5, '{0, 0, 2, 1, 0});
    chk("decode_err", 0, int'(err_o[0]), 0);

    // Out-of-range byte 243 -> 0,0,0,0,0 with err the next cycle.
    send_byte(0, 8'hF3);
    chk("range_err_next", 0, int'(err_o[0]), 1);
    wait_ir(0);
    chk_cap5(0, 10, '{0, 0, 0, 0, 0});
    chk("range_err_sticky", 0, int'(err_o[0]), 1);

    // Backpressure at digit 2 of 45.
    send_byte(0, 8'h2D);
    tick();
    tick();
    out_ready_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_trit",     0, int'(out_trit_o[0]),  2);
      chk("stall_index",    0, int'(out_index_o[0]), 17);
      chk("stall_in_ready", 0, int'(in_ready_o[0]),  0);
      tick();
    end
    out_ready_s[0] = 1'b1;
    wait_ir(0);
    chk("resume_t2", 0, int'(cap[0][17]), 2);
    chk("resume_t3", 0, int'(cap[0][18]), 1);
    chk("resume_t4", 0, int'(cap[0][19]), 0);

    // Partial final byte, 7 trits: clean padding.
    out_ready_s[1] = 1'b1;
    pulse_start(1);
    send_byte(1, 8'h79);
    send_byte(1, 8'h05);
    wait_done(1);
    chk_cap5(1, 0, '{1, 1, 1, 1, 1});
    chk("part_t5",    1, int'(cap[1][5]), 2);
    chk("part_t6",    1, int'(cap[1][6]), 1);
    chk("part_count", 1, cap_n[1], 7);
    chk("part_last",  1, cap_last[1], 6);
    chk("part_err",   1, int'(err_o[1]), 0);
    // Bytes offered after completion are not consumed.
    in_valid_s[1] = 1'b1;
    in_byte_s[1]  = 8'h11;
    tick(); tick(); tick();
    in_valid_s[1] = 1'b0;
    chk("done_held", 1, int'(done_o[1]), 1);

    // Partial final byte with nonzero padding.
    pulse_start(1);
    send_byte(1, 8'h79);
    send_byte(1, 8'h0E);
    wait_done(1);
    chk("pad_t5",  1, int'(cap[1][5]), 2);
    chk("pad_t6",  1, int'(cap[1][6]), 1);
    chk("pad_err", 1, int'(err_o[1]), 1);

    // Restart mid-EMIT clears err and the index.
    pulse_start(0);
    send_byte(0, 8'hF5);
    tick(); tick(); tick();
    chk("pre_restart_index", 0, int'(out_index_o[0]), 3);
    chk("pre_restart_err",   0, int'(err_o[0]), 1);
    pulse_start(0);
    chk("restart_in_ready",  0, int'(in_ready_o[0]), 1);
    chk("restart_out_valid", 0, int'(out_valid_o[0]), 0);
    chk("restart_err",       0, int'(err_o[0]), 0);
    send_byte(0, 8'hFA);
    chk("restart_index", 0, int'(out_index_o[0]), 0);
    chk("restart_trit",  0, int'(out_trit_o[0]), 1);
    chk("restart_err2",  0, int'(err_o[0]), 1);

    // Reset mid-EMIT: everything back to zero.
    rst = 1'b1;
    tick();
    chk("mrst_in_ready",  0, int'(in_ready_o[0]),  0);
    chk("mrst_out_valid", 0, int'(out_valid_o[0]), 0);
    chk("mrst_done",      0, int'(done_o[0]),      0);
    chk("mrst_err",       0, int'(err_o[0]),       0);
    chk("mrst_index",     0, int'(out_index_o[0]), 0);
    chk("mrst_trit",      0, int'(out_trit_o[0]),  0);
    rst = 1'b0;
    tick();

    // Full polynomial at full rate: 840 cycles from first LOAD to DONE.
    in_valid_s[0]  = 1'b1;
    out_ready_s[0] = 1'b1;
    in_byte_s[0]   = 8'(($urandom_range(0, 242)));
    pulse_start(0);
    cycles = 0;
    while (!done_o[0] && cycles < 3000) begin
      in_byte_s[0] = 8'(($urandom_range(0, 242)));
      tick();
      cycles++;
    end
    in_valid_s[0] = 1'b0;
    chk("full_cycles", 0, cycles, 840);
    chk("full_err",    0, int'(err_o[0]), 0);

    // Randomized traffic on both units, checked by the per-cycle model.
    for (int c = 0; c < 4000; c++) begin
      for (int u = 0; u < 2; u++) begin
        in_valid_s[u]  = ($urandom_range(0, 3) != 0);
        in_byte_s[u]   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(243, 255))
                                                     : 8'($urandom_range(0, 242));
        out_ready_s[u] = ($urandom_range(0, 3) != 0);
        start_s[u]     = done_o[u] ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 199) == 0);
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end

    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; in_valid_s[u] = 1'b0;
    end
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
